// File: rtl/cond_botoes.sv
// Pushbutton conditioner: two-flop sync, counter debounce, one-cycle press pulse per button.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses on the buttons selected by REPEAT_MASK.
module cond_botoes #(
    parameter int          N_BTN           = 5,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          REPEAT_DELAY    = 50000000,
    parameter int          REPEAT_PERIOD   = 20000000,
    parameter logic [31:0] REPEAT_MASK     = 32'b11000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 ||
        REPEAT_PERIOD > REPEAT_DELAY || (REPEAT_MASK >> N_BTN) != 32'd0) begin : g_bad_params
        $error("cond_botoes: invalid parameter combination");
    end

    // The synchroniser holds reset-cleared zeros for two edges; until those have
    // flushed, a low s2 is not evidence that the button was actually released.
    logic [1:0] warm_q, warm_d;
    logic       sync_ok;

    always_comb begin
        warm_d  = warm_q;
        sync_ok = (warm_q == 2'd2);
        if (!sync_ok) begin
            warm_d = warm_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            warm_q <= 2'd0;
        end else begin
            warm_q <= warm_d;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic          s1_q, s2_q;
        logic          stable_q, stable_d;
        logic [CW-1:0] db_cnt_q, db_cnt_d;
        logic          arm_q, arm_d;
        logic          level_q;
        logic          pulse_q, pulse_d;
        logic          rep_pulse;

        always_comb begin
            stable_d = stable_q;
            db_cnt_d = '0;
            if (s2_q != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_d = ~stable_q;
                end else begin
                    db_cnt_d = db_cnt_q + CW'(1);
                end
            end
            arm_d   = arm_q | (sync_ok & ~stable_q & ~s2_q);
            // level_q still holds the previous stable value, so this fires on the
            // same edge that btn_level first reads 1.
            pulse_d = (stable_q & ~level_q & arm_q) | rep_pulse;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                db_cnt_q <= '0;
                arm_q    <= 1'b0;
                level_q  <= 1'b0;
                pulse_q  <= 1'b0;
            end else begin
                s1_q     <= btn_raw[gi];
                s2_q     <= s1_q;
                stable_q <= stable_d;
                db_cnt_q <= db_cnt_d;
                arm_q    <= arm_d;
                level_q  <= stable_q;
                pulse_q  <= pulse_d;
            end
        end

`ifdef AUTO_REPEAT_EN
        if (REPEAT_MASK[gi]) begin : g_rep
            localparam int            RW         = $clog2(REPEAT_DELAY);
            localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

            logic [RW-1:0] rep_cnt_q, rep_cnt_d;
            logic          rep_hit;

            // Counts edges since the press pulse; the reload value makes every later
            // hit land exactly REPEAT_PERIOD edges after the previous one.
            always_comb begin
                rep_cnt_d = '0;
                rep_hit   = 1'b0;
                if (stable_q && level_q && arm_q) begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_hit   = 1'b1;
                        rep_cnt_d = REP_RELOAD;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    rep_cnt_q <= '0;
                end else begin
                    rep_cnt_q <= rep_cnt_d;
                end
            end

            assign rep_pulse = rep_hit;
        end else begin : g_norep
            assign rep_pulse = 1'b0;
        end
`else
        assign rep_pulse = 1'b0;
`endif

        assign btn_level[gi] = level_q;
        assign btn_pulse[gi] = pulse_q;
    end

endmodule

// File: tb/tb_cond_botoes.sv
// Scoreboard bench for cond_botoes: stimulus queues expected pulse/level events, monitors pop and compare.
module tb_cond_botoes;

    logic       clock;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    cond_botoes #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .REPEAT_MASK    (32'b11000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } ev_t;

    ev_t pq[$];
    ev_t lq[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_p(input int c, input logic [4:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        pq.push_back(e);
    endtask

    task automatic push_l(input int c, input logic [4:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        lq.push_back(e);
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
            errors++;
            $display("FAIL %s: level=%b pulse=%b, required level=00000 pulse=00000", name, btn_level, btn_pulse);
        end else begin
            $display("ok   %s: outputs clear during reset", name);
        end
    endtask

    // Pulse monitor
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if (btn_pulse !== 5'b0) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: cycle %0d pulse=%b, required no pulse", cyc, btn_pulse);
                end else begin
                    e = pq.pop_front();
                    if (e.cyc != cyc || e.vec !== btn_pulse) begin
                        errors++;
                        $display("FAIL pulse: cycle %0d pulse=%b, required cycle %0d pulse=%b", cyc, btn_pulse, e.cyc, e.vec);
                    end else begin
                        $display("ok   pulse: cycle %0d pulse=%b", cyc, btn_pulse);
                    end
                end
            end
        end
    end

    // Level monitor
    initial begin
        ev_t        e;
        logic [4:0] prev_lvl;
        prev_lvl = 5'b0;
        forever begin
            @(negedge clock);
            if (btn_level !== prev_lvl) begin
                checks++;
                if (lq.size() == 0) begin
                    errors++;
                    $display("FAIL level_unexpected: cycle %0d level=%b, required %b", cyc, btn_level, prev_lvl);
                end else begin
                    e = lq.pop_front();
                    if (e.cyc != cyc || e.vec !== btn_level) begin
                        errors++;
                        $display("FAIL level: cycle %0d level=%b, required cycle %0d level=%b", cyc, btn_level, e.cyc, e.vec);
                    end else begin
                        $display("ok   level: cycle %0d level=%b", cyc, btn_level);
                    end
                end
                prev_lvl = btn_level;
            end
        end
    end

    initial begin
        int k;
        int m;
        int r;

        reset   = 1'b1;
        btn_raw = 5'b0;
        @(negedge clock);
        tick(2);
        check_reset_state("reset_initial");
        reset = 1'b0;
        tick(8);

        // Clean press/release on bit 0
        k = cyc + 1;
        btn_raw[0] = 1'b1;
        push_l(k + 6, 5'b00001);
        push_p(k + 6, 5'b00001);
        tick(30);
        m = cyc + 1;
        btn_raw[0] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(15);

        // Bounce on bit 3 never reaches the debounce threshold
        btn_raw[3] = 1'b1; tick(3);
        btn_raw[3] = 1'b0; tick(1);
        btn_raw[3] = 1'b1; tick(2);
        btn_raw[3] = 1'b0; tick(15);

        // Bit 1 held through reset: level rises, no pulse
        reset      = 1'b1;
        btn_raw[1] = 1'b1;
        tick(1);
        check_reset_state("reset_held_btn");
        tick(2);
        reset = 1'b0;
        r = cyc + 1;
        push_l(r + 6, 5'b00010);
        tick(15);
        m = cyc + 1;
        btn_raw[1] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(15);
        k = cyc + 1;
        btn_raw[1] = 1'b1;
        push_l(k + 6, 5'b00010);
        push_p(k + 6, 5'b00010);
        tick(12);
        m = cyc + 1;
        btn_raw[1] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(15);

        // Simultaneous press on bits 0 and 2
        k = cyc + 1;
        btn_raw[0] = 1'b1;
        btn_raw[2] = 1'b1;
        push_l(k + 6, 5'b00101);
        push_p(k + 6, 5'b00101);
        tick(10);
        m = cyc + 1;
        btn_raw[0] = 1'b0;
        btn_raw[2] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(15);

        // Bit 3 held 60 cycles: repeats only with the feature enabled
        k = cyc + 1;
        btn_raw[3] = 1'b1;
        push_l(k + 6, 5'b01000);
        push_p(k + 6, 5'b01000);
`ifdef AUTO_REPEAT_EN
        for (int i = 0; i < 5; i++) begin
            push_p(k + 26 + 8 * i, 5'b01000);
        end
`endif
        tick(60);
        m = cyc + 1;
        btn_raw[3] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(30);

        // Same hold on unmasked bit 0: single pulse
        k = cyc + 1;
        btn_raw[0] = 1'b1;
        push_l(k + 6, 5'b00001);
        push_p(k + 6, 5'b00001);
        tick(60);
        m = cyc + 1;
        btn_raw[0] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(15);

        // Reset pulse while bit 2's debounce counter is at 2
        btn_raw[2] = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        check_reset_state("reset_mid_debounce");
        reset = 1'b0;
        r = cyc + 1;
        push_l(r + 6, 5'b00100);
        tick(15);
        m = cyc + 1;
        btn_raw[2] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(15);
        k = cyc + 1;
        btn_raw[2] = 1'b1;
        push_l(k + 6, 5'b00100);
        push_p(k + 6, 5'b00100);
        tick(12);
        m = cyc + 1;
        btn_raw[2] = 1'b0;
        push_l(m + 6, 5'b00000);
        tick(20);

        while (pq.size() > 0) begin
            ev_t e;
            e = pq.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_missing: absent, required cycle %0d pulse=%b", e.cyc, e.vec);
        end
        while (lq.size() > 0) begin
            ev_t e;
            e = lq.pop_front();
            checks++;
            errors++;
            $display("FAIL level_missing: absent, required cycle %0d level=%b", e.cyc, e.vec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
